// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared state encoding, line geometry and tag-width helper for dcache_ctrl
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int OFFSET_BITS = 3;
  localparam int WORDS       = 4;

  // Tag is whatever of the 16-bit address is left above index and offset
  function automatic int tagBits(input int idxBits);
    return 16 - OFFSET_BITS - idxBits;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// rtl/dcache_array.sv - direct-mapped tag/valid/dirty/data storage with combinational read
module dcache_array
  import dcache_pkg::*;
#(
  parameter int IDX_BITS = 5,
  parameter int TAG_BITS = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [IDX_BITS-1:0]    idx,
  output logic [TAG_BITS-1:0]    lineTag,
  output logic                   lineValid,
  output logic                   lineDirty,
  output logic [WORDS-1:0][15:0] lineData,
  input  logic                   wrEn,
  input  logic [1:0]             wrWord,
  input  logic [15:0]            wrData,
  input  logic                   tagWe,
  input  logic [TAG_BITS-1:0]    newTag,
  input  logic                   validWe,
  input  logic                   validVal,
  input  logic                   dirtyWe,
  input  logic                   dirtyVal
);

  localparam int LINES = 1 << IDX_BITS;

  logic [TAG_BITS-1:0]    tags [LINES];
  logic [WORDS-1:0][15:0] data [LINES];
  logic [LINES-1:0]       valid;
  logic [LINES-1:0]       dirty;

  assign lineTag   = tags[idx];
  assign lineValid = valid[idx];
  assign lineDirty = dirty[idx];
  assign lineData  = data[idx];

  // Data and tag storage behave like RAM: no reset, written per word / per line
  always_ff @(posedge clk) begin
    if (wrEn)  data[idx][wrWord] <= wrData;
    if (tagWe) tags[idx]         <= newTag;
  end

  // Valid/dirty bits are the only state that reset must clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
      dirty <= '0;
    end else begin
      if (validWe) valid[idx] <= validVal;
      if (dirtyWe) dirty[idx] <= dirtyVal;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - write-back write-allocate data cache controller; DCACHE_PERF_EN adds req/hit counters
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int IDX_BITS = 5,
  parameter int MEM_LAT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        DCacheReq,
  output logic        Err,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wr_data,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [15:0] mem_rd_data,
  input  logic        mem_stall
`ifdef DCACHE_PERF_EN
  ,
  output logic [15:0] req_count,
  output logic [15:0] hit_count
`endif
);

  localparam int TAG_BITS = tagBits(IDX_BITS);

  state_t state, stateNext;

  logic [IDX_BITS-1:0]    idx;
  logic [TAG_BITS-1:0]    tag;
  logic [1:0]             word;
  logic [TAG_BITS-1:0]    lineTag;
  logic                   lineValid, lineDirty;
  logic [WORDS-1:0][15:0] lineData;

  logic                   wrEn, tagWe, validWe, validVal, dirtyWe, dirtyVal;
  logic [1:0]             wrWord;
  logic [15:0]            wrData;

  logic [1:0]             cnt;
  logic                   issued;
  logic                   pipeValid [MEM_LAT];
  logic [1:0]             pipeWord  [MEM_LAT];

  logic                   req, isErr, hit, capture, lastCap, rdAccept;

  assign idx  = Addr[OFFSET_BITS+IDX_BITS-1:OFFSET_BITS];
  assign tag  = Addr[15:OFFSET_BITS+IDX_BITS];
  assign word = Addr[2:1];

  // Gating with reset keeps every output at 0 while reset is held, even with Rd/Wr high
  assign req      = (Rd | Wr) & rst;
  assign isErr    = Addr[0] | (Rd & Wr);
  assign hit      = lineValid & (lineTag == tag);
  assign capture  = pipeValid[MEM_LAT-1];
  assign lastCap  = capture & (pipeWord[MEM_LAT-1] == 2'd3);
  assign rdAccept = mem_rd & ~mem_stall;

  dcache_array #(
    .IDX_BITS(IDX_BITS),
    .TAG_BITS(TAG_BITS)
  ) uArray (
    .clk      (clk),
    .rst      (rst),
    .idx      (idx),
    .lineTag  (lineTag),
    .lineValid(lineValid),
    .lineDirty(lineDirty),
    .lineData (lineData),
    .wrEn     (wrEn),
    .wrWord   (wrWord),
    .wrData   (wrData),
    .tagWe    (tagWe),
    .newTag   (tag),
    .validWe  (validWe),
    .validVal (validVal),
    .dirtyWe  (dirtyWe),
    .dirtyVal (dirtyVal)
  );

  // State, word counter and read-return pipe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= 2'd0;
      issued <= 1'b0;
      for (int i = 0; i < MEM_LAT; i++) begin
        pipeValid[i] <= 1'b0;
        pipeWord[i]  <= 2'd0;
      end
    end else begin
      state <= stateNext;
      case (state)
        WB: if (!mem_stall) cnt <= cnt + 2'd1;
        FILL: if (rdAccept) begin
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) issued <= 1'b1;
        end
        default: begin
          cnt    <= 2'd0;
          issued <= 1'b0;
        end
      endcase
      // The pipe shifts every cycle so mem_stall cannot disturb reads already in flight
      pipeValid[0] <= rdAccept;
      pipeWord[0]  <= cnt;
      for (int i = 1; i < MEM_LAT; i++) begin
        pipeValid[i] <= pipeValid[i-1];
        pipeWord[i]  <= pipeWord[i-1];
      end
    end
  end

  // Next state, handshake outputs, memory requests and array write controls
  always_comb begin
    stateNext   = state;
    Done        = 1'b0;
    Stall       = 1'b0;
    CacheHit    = 1'b0;
    DCacheReq   = 1'b0;
    Err         = 1'b0;
    DataOut     = 16'h0000;
    mem_addr    = 16'h0000;
    mem_wr_data = 16'h0000;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    wrEn        = 1'b0;
    wrWord      = word;
    wrData      = DataIn;
    tagWe       = 1'b0;
    validWe     = 1'b0;
    validVal    = 1'b0;
    dirtyWe     = 1'b0;
    dirtyVal    = 1'b0;
    case (state)
      IDLE: if (req) begin
        if (isErr) begin
          Err  = 1'b1;
          Done = 1'b1;
        end else if (hit) begin
          Done      = 1'b1;
          CacheHit  = 1'b1;
          DCacheReq = 1'b1;
          if (Rd) DataOut = lineData[word];
          if (Wr) begin
            wrEn     = 1'b1;
            dirtyWe  = 1'b1;
            dirtyVal = 1'b1;
          end
        end else begin
          Stall     = 1'b1;
          DCacheReq = 1'b1;
          // Invalidate now so an aborted fill never leaves a half-written line looking valid
          validWe   = 1'b1;
          stateNext = (lineValid && lineDirty) ? WB : FILL;
        end
      end
      WB: begin
        Stall       = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = {lineTag, idx, cnt, 1'b0};
        mem_wr_data = lineData[cnt];
        if (!mem_stall && cnt == 2'd3) stateNext = FILL;
      end
      FILL: begin
        Stall    = 1'b1;
        mem_rd   = ~issued;
        mem_addr = issued ? 16'h0000 : {tag, idx, cnt, 1'b0};
        if (capture) begin
          wrEn   = 1'b1;
          wrWord = pipeWord[MEM_LAT-1];
          wrData = mem_rd_data;
        end
        if (lastCap) begin
          tagWe     = 1'b1;
          validWe   = 1'b1;
          validVal  = 1'b1;
          dirtyWe   = 1'b1;
          stateNext = DONE;
        end
      end
      DONE: begin
        Done = 1'b1;
        if (Rd) DataOut = lineData[word];
        if (Wr) begin
          wrEn     = 1'b1;
          dirtyWe  = 1'b1;
          dirtyVal = 1'b1;
        end
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

`ifdef DCACHE_PERF_EN
  // Saturating request/hit counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_count <= 16'h0000;
      hit_count <= 16'h0000;
    end else begin
      if (DCacheReq && req_count != 16'hFFFF) req_count <= req_count + 16'd1;
      if (CacheHit  && hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - scoreboard bench for dcache_ctrl; DCACHE_PERF_EN also checks the counters
module tb_dcache_ctrl;

  localparam int MEM_LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] Addr = 16'h0000;
  logic [15:0] DataIn = 16'h0000;
  logic        Rd = 1'b0;
  logic        Wr = 1'b0;
  logic [15:0] DataOut;
  logic        Done, Stall, CacheHit, DCacheReq, Err;
  logic [15:0] mem_addr, mem_wr_data;
  logic        mem_rd, mem_wr;
  logic [15:0] mem_rd_data = 16'hDEAD;
  logic        mem_stall = 1'b0;
`ifdef DCACHE_PERF_EN
  logic [15:0] req_count, hit_count;
`endif

  dcache_ctrl #(.IDX_BITS(5), .MEM_LAT(MEM_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .Addr       (Addr),
    .DataIn     (DataIn),
    .Rd         (Rd),
    .Wr         (Wr),
    .DataOut    (DataOut),
    .Done       (Done),
    .Stall      (Stall),
    .CacheHit   (CacheHit),
    .DCacheReq  (DCacheReq),
    .Err        (Err),
    .mem_addr   (mem_addr),
    .mem_wr_data(mem_wr_data),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_rd_data(mem_rd_data),
    .mem_stall  (mem_stall)
`ifdef DCACHE_PERF_EN
    ,
    .req_count  (req_count),
    .hit_count  (hit_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic        chkData;
    logic        hit;
    logic        err;
  } doneExp_t;

  typedef struct {
    logic        isWr;
    logic [15:0] addr;
    logic [15:0] data;
  } memExp_t;

  typedef struct {
    int          due;
    logic [15:0] addr;
  } pend_t;

  doneExp_t    doneQ [$];
  memExp_t     memQ  [$];
  pend_t       pendQ [$];
  doneExp_t    dTmp;
  memExp_t     mTmp;
  pend_t       pTmp;
  logic [15:0] mem [32768];

  int checks = 0, errors = 0, cyc = 0;
  int seenReq = 0, seenHit = 0, expReq = 0, expHit = 0;
  int stallLeft = 0;
  logic [15:0] stallAddr = 16'h0000;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc = cyc + 1;

  // Memory back-pressure: stall a chosen read address for stallLeft cycles
  always @(posedge clk) begin
    #2;
    if (stallLeft > 0 && mem_rd && mem_addr == stallAddr) begin
      mem_stall = 1'b1;
      stallLeft--;
    end else begin
      mem_stall = 1'b0;
    end
  end

  // Monitor: pops expectations on Done and on accepted memory ops, and models memory
  always @(negedge clk) begin
    if (rst) begin
      chk("done_with_stall", {15'd0, Done & Stall}, 16'd0);
      chk("rd_and_wr", {15'd0, mem_rd & mem_wr}, 16'd0);
      if (DCacheReq) seenReq++;
      if (CacheHit) seenHit++;
      if (Done) begin
        if (doneQ.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done actual=1 expected=0 addr=%h", Addr);
        end else begin
          dTmp = doneQ.pop_front();
          chk("done_hit", {15'd0, CacheHit}, {15'd0, dTmp.hit});
          chk("done_err", {15'd0, Err}, {15'd0, dTmp.err});
          chk("done_req", {15'd0, DCacheReq}, {15'd0, dTmp.hit});
          if (dTmp.chkData) chk("done_data", DataOut, dTmp.data);
        end
      end
      if ((mem_rd || mem_wr) && mem_stall && memQ.size() > 0)
        chk("stall_addr_hold", mem_addr, memQ[0].addr);
      if ((mem_rd || mem_wr) && !mem_stall) begin
        if (memQ.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_mem_op actual=%h expected=none", mem_addr);
        end else begin
          mTmp = memQ.pop_front();
          chk("mem_kind", {15'd0, mem_wr}, {15'd0, mTmp.isWr});
          chk("mem_addr", mem_addr, mTmp.addr);
          if (mTmp.isWr) chk("mem_wr_data", mem_wr_data, mTmp.data);
        end
        if (mem_wr) mem[mem_addr[15:1]] = mem_wr_data;
        if (mem_rd) pendQ.push_back('{cyc + MEM_LAT, mem_addr});
      end
    end else begin
      seenReq = 0;
      seenHit = 0;
      pendQ.delete();
    end
    mem_rd_data = 16'hDEAD;
    if (pendQ.size() > 0 && pendQ[0].due == cyc) begin
      pTmp = pendQ.pop_front();
      mem_rd_data = mem[pTmp.addr[15:1]];
    end
  end

  task automatic pushRd(input logic [15:0] base);
    for (int i = 0; i < 4; i++) memQ.push_back('{1'b0, base + 16'(2 * i), 16'h0000});
  endtask

  task automatic pushWr(input logic [15:0] base, input logic [15:0] w0, w1, w2, w3);
    memQ.push_back('{1'b1, base,          w0});
    memQ.push_back('{1'b1, base + 16'd2,  w1});
    memQ.push_back('{1'b1, base + 16'd4,  w2});
    memQ.push_back('{1'b1, base + 16'd6,  w3});
  endtask

  task automatic access(input logic rdI, wrI, input logic [15:0] a, d, expData,
                        input logic chkD, hitE, errE);
    bit seen = 0;
    doneQ.push_back('{expData, chkD, hitE, errE});
    if (!errE) begin
      expReq++;
      if (hitE) expHit++;
    end
    @(posedge clk); #1;
    Rd = rdI; Wr = wrI; Addr = a; DataIn = d;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (Done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL done_timeout actual=0 expected=1 addr=%h", a);
    end
    @(posedge clk); #1;
    Rd = 1'b0; Wr = 1'b0;
  endtask

  task automatic load(input logic [15:0] a, expData, input logic hitE);
    access(1'b1, 1'b0, a, 16'h0000, expData, 1'b1, hitE, 1'b0);
  endtask

  task automatic checkAllZero();
    chk("rst_done", {15'd0, Done}, 16'd0);
    chk("rst_stall", {15'd0, Stall}, 16'd0);
    chk("rst_hit", {15'd0, CacheHit}, 16'd0);
    chk("rst_req", {15'd0, DCacheReq}, 16'd0);
    chk("rst_err", {15'd0, Err}, 16'd0);
    chk("rst_dataout", DataOut, 16'h0000);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_mem_wr_data", mem_wr_data, 16'h0000);
    chk("rst_mem_rd", {15'd0, mem_rd}, 16'd0);
    chk("rst_mem_wr", {15'd0, mem_wr}, 16'd0);
`ifdef DCACHE_PERF_EN
    chk("rst_req_count", req_count, 16'h0000);
    chk("rst_hit_count", hit_count, 16'h0000);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int acc;
    for (int i = 0; i < 32768; i++) mem[i] = 16'hA000 | 16'(i & 16'h0FFF);
    mem[16'h0008] = 16'hBEEF;

    // Reset held with a load request pending: outputs must stay 0
    Rd = 1'b1; Addr = 16'h0010;
    repeat (2) @(negedge clk);
    checkAllZero();
    @(posedge clk); #1;
    Rd = 1'b0; rst = 1'b1;

    // Cold load, repeat hit
    pushRd(16'h0010);
    load(16'h0010, 16'hBEEF, 1'b0);
    load(16'h0010, 16'hBEEF, 1'b1);

    // Store hit, then conflicting load forces writeback of the dirty line
    access(1'b0, 1'b1, 16'h0012, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0);
    pushWr(16'h0010, 16'hBEEF, 16'h1234, 16'hA00A, 16'hA00B);
    pushRd(16'h0110);
    load(16'h0112, 16'hA089, 1'b0);

    // Clean victim: straight refill, written-back data returns from memory
    pushRd(16'h0010);
    load(16'h0010, 16'hBEEF, 1'b0);
    load(16'h0012, 16'h1234, 1'b1);

    // Three stall cycles on the second read of a fill
    stallAddr = 16'h0022; stallLeft = 3;
    pushRd(16'h0020);
    load(16'h0020, 16'hA010, 1'b0);
    chk("stall_consumed", 16'(stallLeft), 16'd0);
    load(16'h0022, 16'hA011, 1'b1);
    load(16'h0024, 16'hA012, 1'b1);
    load(16'h0026, 16'hA013, 1'b1);

    // Error cases: odd address, and Rd with Wr
    access(1'b1, 1'b0, 16'h0011, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    access(1'b1, 1'b1, 16'h0010, 16'h5555, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk("req_pulses_pre_reset", 16'(seenReq), 16'(expReq));
    chk("hit_pulses_pre_reset", 16'(seenHit), 16'(expHit));

    // Reset after two fill reads have been accepted
    expReq++;
    memQ.push_back('{1'b0, 16'h0030, 16'h0000});
    memQ.push_back('{1'b0, 16'h0032, 16'h0000});
    @(posedge clk); #1;
    Rd = 1'b1; Addr = 16'h0030;
    acc = 0;
    for (int n = 0; n < 100 && acc < 2; n++) begin
      @(negedge clk);
      if (mem_rd && !mem_stall) acc++;
    end
    chk("reads_before_reset", 16'(acc), 16'd2);
    @(posedge clk); #1;
    rst = 1'b0; expReq = 0; expHit = 0;
    @(negedge clk);
    checkAllZero();
    @(posedge clk); #1;
    Rd = 1'b0; rst = 1'b1;

    // Post-reset: 3 misses and 5 hits
    pushRd(16'h0030);
    load(16'h0030, 16'hA018, 1'b0);
    load(16'h0032, 16'hA019, 1'b1);
    load(16'h0034, 16'hA01A, 1'b1);
    load(16'h0036, 16'hA01B, 1'b1);
    load(16'h0030, 16'hA018, 1'b1);
    pushRd(16'h0040);
    load(16'h0040, 16'hA020, 1'b0);
    load(16'h0042, 16'hA021, 1'b1);
    pushRd(16'h0050);
    load(16'h0050, 16'hA028, 1'b0);

    repeat (3) @(negedge clk);
    chk("done_queue_empty", 16'(doneQ.size()), 16'd0);
    chk("mem_queue_empty", 16'(memQ.size()), 16'd0);
    chk("req_pulses", 16'(seenReq), 16'd8);
    chk("hit_pulses", 16'(seenHit), 16'd5);
`ifdef DCACHE_PERF_EN
    chk("req_count", req_count, 16'd8);
    chk("hit_count", hit_count, 16'd5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
